// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, fetch FSM state encoding, fetch error
// codes and branch-control encodings used by the fetch and branch stages.
package cpu_pkg;

   localparam int unsigned WORD_W = 32;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      ISSUE = 2'd2,
      STOP  = 2'd3
   } fetch_state_t;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'b00,
      ERR_MISALIGN = 2'b01,
      ERR_TIMEOUT  = 2'b10
   } fetch_err_t;

   typedef enum logic [2:0] {
      BR_NB  = 3'b000,
      BR_BR  = 3'b001,
      BR_BMI = 3'b010,
      BR_BPL = 3'b011,
      BR_BZ  = 3'b100
   } branch_t;

   // A fetch target is legal only on a 32-bit word boundary.
   function automatic logic word_aligned(input word_t addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory read port.
//   IMEM_REQ  : read request (fetch side drives)
//   IMEM_ADDR : read address (fetch side drives)
//   IMEM_ACK  : read data valid this cycle (memory side drives)
//   IMEM_DATA : instruction word, qualified by IMEM_ACK (memory side drives)
interface fetch_unit_if;
   import cpu_pkg::*;

   logic  IMEM_REQ;
   word_t IMEM_ADDR;
   logic  IMEM_ACK;
   word_t IMEM_DATA;

   modport master (
      output IMEM_REQ,
      output IMEM_ADDR,
      input  IMEM_ACK,
      input  IMEM_DATA
   );

   modport slave (
      input  IMEM_REQ,
      input  IMEM_ADDR,
      output IMEM_ACK,
      output IMEM_DATA
   );

endinterface

// File: rtl/fetch_timeout.sv
// Wait counter for an outstanding instruction-memory request.
//   clk, rst : clock and synchronous active-high reset
//   clear    : return the count to zero (takes priority over enable)
//   enable   : advance the count by one
//   tc       : count has reached ACK_TIMEOUT-1, i.e. the current waiting
//              cycle is the last one allowed
module fetch_timeout #(
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tc
);

   localparam logic [7:0] TC_VAL = 8'(ACK_TIMEOUT - 1);

   logic [7:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   always_comb begin
      tc = (count == TC_VAL);
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests the word at PC, latches it into IR,
// holds it as the issued instruction until the branch stage resolves the
// next PC or a halt is decoded, and stops on halt, misaligned target or
// memory timeout.
//   clk, rst    : clock, synchronous active-high reset
//   imem        : instruction-memory read port (master side)
//   NPC         : next PC from branch control, taken when NPC_valid
//   NPC_valid   : next-PC strobe, honoured only in ISSUE
//   HALT        : halt for the issued instruction, honoured only in ISSUE
//   PC          : address of the current instruction
//   PC_plus_4   : PC + 4 (wraps at 32 bits)
//   IR          : latched instruction
//   IR_valid    : IR/PC describe an issued instruction
//   INSTR_COUNT : number of issued instructions (wraps)
//   HALTED      : fetch stopped
//   ERR         : 00 none, 01 misaligned NPC, 10 memory timeout
module fetch_unit
   import cpu_pkg::*;
#(
   parameter word_t       RESET_PC    = 32'h0000_0000,
   parameter int unsigned ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   fetch_unit_if.master     imem,
   input  word_t            NPC,
   input  logic             NPC_valid,
   input  logic             HALT,
   output word_t            PC,
   output word_t            PC_plus_4,
   output word_t            IR,
   output logic             IR_valid,
   output word_t            INSTR_COUNT,
   output logic             HALTED,
   output logic [1:0]       ERR
);

   fetch_state_t state, state_n;
   fetch_err_t   err_q;
   word_t        pc_q;
   word_t        ir_q;
   word_t        count_q;

   logic ack_in_fetch;
   logic to_clear;
   logic to_enable;
   logic to_tc;
   logic timed_out;
   logic npc_ok;

   always_comb begin
      ack_in_fetch = (state == FETCH) && imem.IMEM_ACK;
      // Counter sits at zero outside FETCH, so every entry to FETCH starts clean.
      to_clear     = (state != FETCH);
      to_enable    = (state == FETCH) && !imem.IMEM_ACK;
      // ACK in the terminal cycle wins over the timeout.
      timed_out    = to_enable && to_tc;
      npc_ok       = word_aligned(NPC);
   end

   fetch_timeout #(
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (to_clear),
      .enable (to_enable),
      .tc     (to_tc)
   );

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next-state logic
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:  state_n = FETCH;
         FETCH: begin
            if (ack_in_fetch) begin
               state_n = ISSUE;
            end else if (timed_out) begin
               state_n = STOP;
            end
         end
         ISSUE: begin
            if (HALT) begin
               state_n = STOP;
            end else if (NPC_valid) begin
               state_n = npc_ok ? FETCH : STOP;
            end
         end
         STOP:  state_n = STOP;
         default: state_n = IDLE;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         ir_q    <= '0;
         count_q <= '0;
         err_q   <= ERR_NONE;
      end else begin
         if (ack_in_fetch) begin
            ir_q    <= imem.IMEM_DATA;
            count_q <= count_q + 32'd1;
         end else if (timed_out) begin
            err_q <= ERR_TIMEOUT;
         end

         if ((state == ISSUE) && !HALT && NPC_valid) begin
            if (npc_ok) begin
               pc_q <= NPC;
            end else begin
               err_q <= ERR_MISALIGN;
            end
         end
      end
   end

   // Outputs; status strobes are held low while rst is asserted.
   always_comb begin
      imem.IMEM_REQ  = (state == FETCH) && !rst;
      imem.IMEM_ADDR = pc_q;
      IR_valid       = (state == ISSUE) && !rst;
      HALTED         = (state == STOP) && !rst;
      PC             = pc_q;
      PC_plus_4      = pc_q + 32'd4;
      IR             = ir_q;
      INSTR_COUNT    = count_q;
      ERR            = err_q;
   end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

   localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
   localparam int          TB_TO       = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] npc;
   logic        npc_valid;
   logic        halt;
   logic [31:0] pc, pc_plus_4, ir, instr_count;
   logic        ir_valid, halted;
   logic [1:0]  err;

   int n_vec = 0;
   int n_err = 0;

   fetch_unit_if imem ();

   fetch_unit #(
      .RESET_PC    (TB_RESET_PC),
      .ACK_TIMEOUT (TB_TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem),
      .NPC         (npc),
      .NPC_valid   (npc_valid),
      .HALT        (halt),
      .PC          (pc),
      .PC_plus_4   (pc_plus_4),
      .IR          (ir),
      .IR_valid    (ir_valid),
      .INSTR_COUNT (instr_count),
      .HALTED      (halted),
      .ERR         (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic a, input logic [31:0] d,
                        input logic nv, input logic [31:0] n, input logic h);
      rst            = r;
      imem.IMEM_ACK  = a;
      imem.IMEM_DATA = d;
      npc_valid      = nv;
      npc            = n;
      halt           = h;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic e_req, input logic [31:0] e_pc,
                            input logic [31:0] e_ir, input logic e_irv, input logic e_halted,
                            input logic [1:0] e_err, input logic [31:0] e_cnt);
      chk({tag, "_req"},    {31'd0, imem.IMEM_REQ}, {31'd0, e_req});
      chk({tag, "_addr"},   imem.IMEM_ADDR, e_pc);
      chk({tag, "_pc"},     pc, e_pc);
      chk({tag, "_pc4"},    pc_plus_4, e_pc + 32'd4);
      chk({tag, "_ir"},     ir, e_ir);
      chk({tag, "_irv"},    {31'd0, ir_valid}, {31'd0, e_irv});
      chk({tag, "_halted"}, {31'd0, halted}, {31'd0, e_halted});
      chk({tag, "_err"},    {30'd0, err}, {30'd0, e_err});
      chk({tag, "_cnt"},    instr_count, e_cnt);
   endtask

   // Directed vector table
   typedef struct {
      logic        rst;
      logic        ack;
      logic [31:0] data;
      logic        npcv;
      logic [31:0] npc;
      logic        halt;
      logic        e_req;
      logic [31:0] e_pc;
      logic [31:0] e_ir;
      logic        e_irv;
      logic        e_halted;
      logic [1:0]  e_err;
      logic [31:0] e_cnt;
   } vec_t;

   vec_t tbl[10];

   // Behavioural reference: which phase of the fetch cycle the unit is in,
   // plus architectural values, advanced from the rules per sampled edge.
   bit          m_idle, m_fetching, m_issued, m_stopped;
   int          m_waited;
   logic [31:0] m_pc, m_ir, m_cnt;
   logic [1:0]  m_err;

   task automatic model_edge(input logic r, input logic a, input logic [31:0] d,
                             input logic nv, input logic [31:0] n, input logic h);
      if (r) begin
         m_idle = 1; m_fetching = 0; m_issued = 0; m_stopped = 0; m_waited = 0;
         m_pc = TB_RESET_PC; m_ir = 0; m_cnt = 0; m_err = 2'b00;
      end else if (m_idle) begin
         m_idle = 0; m_fetching = 1; m_waited = 0;
      end else if (m_fetching) begin
         if (a) begin
            m_ir = d; m_cnt = m_cnt + 1; m_fetching = 0; m_issued = 1;
         end else begin
            m_waited++;
            if (m_waited >= TB_TO) begin
               m_err = 2'b10; m_fetching = 0; m_stopped = 1;
            end
         end
      end else if (m_issued) begin
         if (h) begin
            m_issued = 0; m_stopped = 1;
         end else if (nv) begin
            m_issued = 0;
            if (n % 4 == 0) begin
               m_pc = n; m_fetching = 1; m_waited = 0;
            end else begin
               m_err = 2'b01; m_stopped = 1;
            end
         end
      end
   endtask

   initial begin
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);

      //            rst  ack  data          nv   npc           halt req  pc            ir            irv  hlt  err    cnt
      tbl[0] = '{1'b1, 1'b1, 32'hFFFF_0000, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 32'd0};
      tbl[1] = '{1'b0, 1'b0, 32'h0,         1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        32'h0,        1'b0, 1'b0, 2'b00, 32'd0};
      tbl[2] = '{1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h0,        1'b0, 1'b0, 32'h0,        32'h1234_5678, 1'b1, 1'b0, 2'b00, 32'd1};
      tbl[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h8,        1'b0, 1'b1, 32'h8,        32'h1234_5678, 1'b0, 1'b0, 2'b00, 32'd1};
      tbl[4] = '{1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8,        32'hAAAA_0001, 1'b1, 1'b0, 2'b00, 32'd2};
      tbl[5] = '{1'b0, 1'b1, 32'h5555_5555, 1'b0, 32'h0,        1'b0, 1'b0, 32'h8,        32'hAAAA_0001, 1'b1, 1'b0, 2'b00, 32'd2};
      tbl[6] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h40,       1'b0, 1'b1, 32'h40,       32'hAAAA_0001, 1'b0, 1'b0, 2'b00, 32'd2};
      tbl[7] = '{1'b0, 1'b1, 32'h0000_BEEF, 1'b0, 32'h0,        1'b0, 1'b0, 32'h40,       32'h0000_BEEF, 1'b1, 1'b0, 2'b00, 32'd3};
      tbl[8] = '{1'b0, 1'b0, 32'h0,         1'b1, 32'h42,       1'b0, 1'b0, 32'h40,       32'h0000_BEEF, 1'b0, 1'b1, 2'b01, 32'd3};
      tbl[9] = '{1'b0, 1'b1, 32'h1111_1111, 1'b1, 32'h80,       1'b1, 1'b0, 32'h40,       32'h0000_BEEF, 1'b0, 1'b1, 2'b01, 32'd3};

      for (int i = 0; i < 10; i++) begin
         drive(tbl[i].rst, tbl[i].ack, tbl[i].data, tbl[i].npcv, tbl[i].npc, tbl[i].halt);
         tick();
         check_all($sformatf("tbl%0d", i), tbl[i].e_req, tbl[i].e_pc, tbl[i].e_ir,
                   tbl[i].e_irv, tbl[i].e_halted, tbl[i].e_err, tbl[i].e_cnt);
      end

      // Timeout: four FETCH cycles without ACK end in STOP with ERR=10.
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      for (int i = 1; i < TB_TO; i++) begin
         tick();
         check_all($sformatf("to_wait%0d", i), 1'b1, 32'h0, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
      end
      tick();
      check_all("to_stop", 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 2'b10, 32'd0);

      // ACK in the terminal cycle wins.
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      for (int i = 1; i < TB_TO; i++) tick();
      drive(1'b0, 1'b1, 32'hCAFE_0004, 1'b0, '0, 1'b0); tick();
      check_all("to_ack", 1'b0, 32'h0, 32'hCAFE_0004, 1'b1, 1'b0, 2'b00, 32'd1);

      // HALT beats NPC_valid in the same ISSUE cycle.
      drive(1'b0, 1'b0, '0, 1'b1, 32'h100, 1'b1); tick();
      check_all("halt_npc", 1'b0, 32'h0, 32'hCAFE_0004, 1'b0, 1'b1, 2'b00, 32'd1);

      // Reset in the second FETCH cycle with a coincident ACK.
      drive(1'b1, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      drive(1'b0, 1'b1, 32'h0000_0011, 1'b0, '0, 1'b0); tick();
      drive(1'b0, 1'b0, '0, 1'b1, 32'h20, 1'b0); tick();
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      check_all("rfetch_pre", 1'b1, 32'h20, 32'h0000_0011, 1'b0, 1'b0, 2'b00, 32'd1);
      drive(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, '0, 1'b0);
      #1;
      chk("rfetch_req_during", {31'd0, imem.IMEM_REQ}, 32'd0);
      tick();
      check_all("rfetch_rst", 1'b0, TB_RESET_PC, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);
      drive(1'b0, 1'b0, '0, 1'b0, '0, 1'b0); tick();
      check_all("rfetch_restart", 1'b1, TB_RESET_PC, 32'h0, 1'b0, 1'b0, 2'b00, 32'd0);

      // Randomised run against the reference model.
      for (int c = 0; c < 3000; c++) begin
         logic        r, a, nv, h;
         logic [31:0] d, n;
         r  = (c == 0) || ($urandom_range(0, 49) == 0);
         a  = ($urandom_range(0, 2) == 0);
         d  = $urandom;
         nv = ($urandom_range(0, 2) == 0);
         n  = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(0, 9) == 0) n[1:0] = 2'($urandom_range(1, 3));
         if ($urandom_range(0, 199) == 0) n = 32'hFFFF_FFFC;
         h  = ($urandom_range(0, 19) == 0);
         drive(r, a, d, nv, n, h);
         tick();
         model_edge(r, a, d, nv, n, h);
         check_all("rnd", m_fetching, m_pc, m_ir, m_issued, m_stopped, m_err, m_cnt);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
